tx_arbiter: RTL and testbench
=============================

// Module: tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single TX handshake unit between N routercore requesters (e.g. local + forwarded flows).
//  Sits between the requesters and tx_handshake: drives rc_has_data/data_to_tx, watches tx_ready.
//  Grants exactly one packet per handoff and acks the winning requester on the accepting cycle.
// PARAMETERS
//  N_PORTS  4   number of requesters (2..8)
//  DATA_W   55  packet width; matches the TX data bus
//  PTR_W    2   index width, clog2(N_PORTS); localparam
// PORTS
//  clk          in   1               system clock
//  rst_n        in   1               asynchronous active-low reset
//  req          in   N_PORTS         per-port request; held with data until ack
//  req_data     in   N_PORTS*DATA_W  port i data at [i*DATA_W +: DATA_W]
//  port_en      in   N_PORTS         per-port enable mask; disabled ports are never granted
//  ack          out  N_PORTS         one-hot, 1-cycle pulse on handoff of that port's packet
//  tx_ready     in   1               from TX handshake; high = new data may be offered
//  rc_has_data  out  1               to TX handshake; offer valid
//  data_to_tx   out  DATA_W          to TX handshake; granted port's data
//  busy         out  1               high in GRANT or DRAIN
//  gnt_idx      out  PTR_W           currently/last granted port index
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, gnt_idx=0; ack=0, rc_has_data=0, data_to_tx=0, busy=0.
//  FSM states: IDLE, GRANT, DRAIN (registered; outputs decoded from state + inputs).
//  IDLE: eligible = req & port_en. If nonzero, pick first eligible at/after rr_ptr (wrap N_PORTS-1 -> 0);
//   register gnt_idx, go GRANT. Else stay.
//  GRANT: rc_has_data = req[gnt_idx]; data_to_tx = req_data[gnt_idx] (muxed, stable while granted).
//   accept = req[gnt_idx] & tx_ready. On accept: ack[gnt_idx]=1 same cycle, rr_ptr <= gnt_idx+1 (wrap), go DRAIN.
//   If req[gnt_idx] drops or port_en[gnt_idx] drops before accept: no ack, rc_has_data=0, go IDLE, rr_ptr unchanged.
//   tx_ready low in GRANT: hold offer, wait (no timeout).
//  DRAIN: rc_has_data=0, data_to_tx holds last value; stay until tx_ready observed low, then IDLE.
//   Prevents double-offer while TX unit has not yet left its ready state.
//  Latency: req asserted cycle 0 with TX ready -> rc_has_data cycle 1 -> ack cycle 1 -> next offer earliest
//   after tx_ready has fallen and risen again.
//  Outside GRANT: rc_has_data=0 and ack=0 always. ack never asserts for more than one cycle per packet.
//  Fairness: with all ports requesting continuously, grants cycle 0,1,..,N-1,0; no port waits > N-1 handoffs.
//  Simultaneous new req on the just-acked port: that port is lowest priority for the next grant.
//  rst_n low mid-GRANT/DRAIN: immediate return to reset values; in-flight offer is dropped, no ack.
//  data_to_tx defined 0 in IDLE (no X propagation into the TX data register).
// STRUCTURE
//  Shared package/include: state encodings (IDLE/GRANT/DRAIN), DATA_W=55 packet width constant.
//  Sub-module rr_pick (N_PORTS): combinational first-set-at-or-after-pointer with wrap; outputs idx + found.
//  Top: FSM, rr_ptr/gnt_idx registers, data mux, ack decode.
// TESTING
//  Single req: req=0001, tx_ready=1 -> rc_has_data cycle 1, data_to_tx=req_data[0], ack=0001 one cycle, busy then 0.
//  All four req held, tx_ready toggling like TX unit -> ack order 0,1,2,3,0 with one ack per tx_ready low pulse.
//  port_en=1011, req=1111 -> port 2 never acked; order 0,1,3,0.
//  tx_ready held low for 20 cycles in GRANT -> rc_has_data high, data stable, ack=0 throughout; accept on rise.
//  req[1] withdrawn in GRANT before tx_ready -> no ack, back to IDLE, next grant port 1 again if re-requested.
//  rst_n pulsed low mid-DRAIN -> all outputs 0 asynchronously; after release, fresh req=0100 granted first.
//  Bench TX model replicates the handshake unit (ready low while transferring, data sampled on offer).

Source files
------------

// File: rtl/tx_arbiter_pkg.sv
// Shared constants for the TX arbiter: FSM state encodings and default sizes.
package tx_arbiter_pkg;

  localparam int TX_DATA_W   = 55;
  localparam int DEF_N_PORTS = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/tx_arbiter_if.sv
// Requester/TX-side bundle of the arbiter; the slave modport is the arbiter's view.
interface tx_arbiter_if
  import tx_arbiter_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int DATA_W  = TX_DATA_W
);
  localparam int PTR_W = $clog2(N_PORTS);

  logic [N_PORTS-1:0]        req;
  logic [N_PORTS*DATA_W-1:0] req_data;
  logic [N_PORTS-1:0]        port_en;
  logic [N_PORTS-1:0]        ack;
  logic                      tx_ready;
  logic                      rc_has_data;
  logic [DATA_W-1:0]         data_to_tx;
  logic                      busy;
  logic [PTR_W-1:0]          gnt_idx;

  modport master (
    output req, req_data, port_en, tx_ready,
    input  ack, rc_has_data, data_to_tx, busy, gnt_idx
  );

  modport slave (
    input  req, req_data, port_en, tx_ready,
    output ack, rc_has_data, data_to_tx, busy, gnt_idx
  );

endinterface

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit at or after the pointer, wrapping to 0.
module rr_pick #(
  parameter  int N_PORTS = 4,
  localparam int PTR_W   = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] i_elig,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [PTR_W-1:0]   o_idx,
  output logic               o_found
);

  // Scan from farthest to nearest so the closest eligible port wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (i_elig[(int'(i_ptr) + k) % N_PORTS]) begin
        o_found = 1'b1;
        o_idx   = PTR_W'((int'(i_ptr) + k) % N_PORTS);
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter handing one packet at a time from N requesters to the TX handshake unit.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int DATA_W  = TX_DATA_W
) (
  input  logic        clk,
  input  logic        rst_n,
  tx_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(N_PORTS);

  logic [1:0]         r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_gnt_idx;
  logic [DATA_W-1:0]  r_hold_data;

  logic [N_PORTS-1:0] w_elig;
  logic [PTR_W-1:0]   w_pick_idx;
  logic               w_pick_found;
  logic               w_gnt_live;
  logic               w_accept;
  logic [DATA_W-1:0]  w_gnt_data;
  logic [DATA_W-1:0]  w_data_out;

  assign w_elig = bus.req & bus.port_en;

  rr_pick #(.N_PORTS(N_PORTS)) u_rr_pick (
    .i_elig  (w_elig),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  // The grant stays valid only while the owner keeps requesting and stays enabled.
  assign w_gnt_live = bus.req[r_gnt_idx] & bus.port_en[r_gnt_idx];
  assign w_accept   = (r_state == ST_GRANT) & w_gnt_live & bus.tx_ready;
  assign w_gnt_data = bus.req_data[r_gnt_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_gnt_idx   <= '0;
      r_hold_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_found) begin
            r_gnt_idx <= w_pick_idx;
            r_state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!w_gnt_live) begin
            r_state <= ST_IDLE;
          end else if (bus.tx_ready) begin
            r_rr_ptr    <= (r_gnt_idx == PTR_W'(N_PORTS - 1)) ? '0 : r_gnt_idx + 1'b1;
            r_hold_data <= w_gnt_data;
            r_state     <= ST_DRAIN;
          end
        end
        // Wait for the TX unit to leave ready so the same slot is never offered twice.
        ST_DRAIN: begin
          if (!bus.tx_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    case (r_state)
      ST_GRANT: w_data_out = w_gnt_data;
      ST_DRAIN: w_data_out = r_hold_data;
      default:  w_data_out = '0;
    endcase
  end

  assign bus.rc_has_data = (r_state == ST_GRANT) & w_gnt_live;
  assign bus.ack         = w_accept ? (N_PORTS'(1) << r_gnt_idx) : '0;
  assign bus.data_to_tx  = w_data_out;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.gnt_idx     = r_gnt_idx;

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios plus a randomized run against a spec-level model.
module tb_tx_arbiter;

  localparam int NP = 4;
  localparam int DW = 55;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  int checkCount = 0;
  int passCount  = 0;

  logic [DW-1:0] portData [NP];
  int            ackLog [$];
  int            ackErr;

  tx_arbiter_if #(.N_PORTS(NP), .DATA_W(DW)) bus ();

  tx_arbiter #(.N_PORTS(NP), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] randData();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic driveData();
    for (int i = 0; i < NP; i++) bus.req_data[i*DW +: DW] = portData[i];
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    bus.req = '0;
    bus.port_en = '0;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < NP; i++) portData[i] = '0;
    driveData();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // TX unit model: samples an offer when ready, then drops ready for two cycles.
  task automatic run_tx(input int maxCycles, input int wantAcks);
    int lowLeft = 0;
    bit accepted;
    logic [NP-1:0] prevAck = '0;
    ackLog.delete();
    ackErr = 0;
    for (int c = 0; c < maxCycles && ackLog.size() < wantAcks; c++) begin
      @(negedge clk);
      accepted = bus.rc_has_data && bus.tx_ready;
      if (bus.ack != '0) begin
        if (!$onehot(bus.ack) || prevAck != '0 || !accepted) ackErr++;
        for (int i = 0; i < NP; i++)
          if (bus.ack[i]) begin
            ackLog.push_back(i);
            if (bus.data_to_tx !== portData[i]) ackErr++;
          end
      end
      prevAck = bus.ack;
      @(posedge clk);
      #1;
      if (accepted) lowLeft = 2;
      else if (lowLeft > 0) lowLeft--;
      bus.tx_ready = (lowLeft == 0);
    end
  endtask

  task automatic test_reset();
    bus.req = 4'b1111;
    bus.port_en = 4'b1111;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < NP; i++) portData[i] = randData();
    driveData();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkCount++; if (bus.rc_has_data !== 1'b0) $display("[TB] FAIL reset_rc: got %b expected 0", bus.rc_has_data); else passCount++;
    checkCount++; if (bus.ack !== 4'b0000) $display("[TB] FAIL reset_ack: got %b expected 0000", bus.ack); else passCount++;
    checkCount++; if (bus.data_to_tx !== '0) $display("[TB] FAIL reset_data: got %h expected 0", bus.data_to_tx); else passCount++;
    checkCount++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); else passCount++;
    checkCount++; if (bus.gnt_idx !== 2'd0) $display("[TB] FAIL reset_gnt_idx: got %0d expected 0", bus.gnt_idx); else passCount++;
  endtask

  task automatic test_single();
    applyReset();
    portData[0] = randData();
    driveData();
    bus.port_en = 4'b1111;
    bus.req = 4'b0001;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    checkCount++; if (bus.rc_has_data !== 1'b0) $display("[TB] FAIL single_c0_rc: got %b expected 0", bus.rc_has_data); else passCount++;
    @(negedge clk);
    checkCount++; if (bus.rc_has_data !== 1'b1) $display("[TB] FAIL single_c1_rc: got %b expected 1", bus.rc_has_data); else passCount++;
    checkCount++; if (bus.data_to_tx !== portData[0]) $display("[TB] FAIL single_c1_data: got %h expected %h", bus.data_to_tx, portData[0]); else passCount++;
    checkCount++; if (bus.ack !== 4'b0001) $display("[TB] FAIL single_c1_ack: got %b expected 0001", bus.ack); else passCount++;
    checkCount++; if (bus.busy !== 1'b1) $display("[TB] FAIL single_c1_busy: got %b expected 1", bus.busy); else passCount++;
    @(posedge clk);
    #1;
    bus.req = 4'b0000;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    checkCount++; if (bus.ack !== 4'b0000) $display("[TB] FAIL single_drain_ack: got %b expected 0000", bus.ack); else passCount++;
    checkCount++; if (bus.rc_has_data !== 1'b0) $display("[TB] FAIL single_drain_rc: got %b expected 0", bus.rc_has_data); else passCount++;
    checkCount++; if (bus.busy !== 1'b1) $display("[TB] FAIL single_drain_busy: got %b expected 1", bus.busy); else passCount++;
    checkCount++; if (bus.data_to_tx !== portData[0]) $display("[TB] FAIL single_drain_data: got %h expected %h", bus.data_to_tx, portData[0]); else passCount++;
    @(posedge clk);
    #1;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    checkCount++; if (bus.busy !== 1'b0) $display("[TB] FAIL single_idle_busy: got %b expected 0", bus.busy); else passCount++;
    checkCount++; if (bus.data_to_tx !== '0) $display("[TB] FAIL single_idle_data: got %h expected 0", bus.data_to_tx); else passCount++;
  endtask

  task automatic test_fair_all();
    int expOrder [5] = '{0, 1, 2, 3, 0};
    applyReset();
    for (int i = 0; i < NP; i++) portData[i] = randData();
    driveData();
    bus.port_en = 4'b1111;
    bus.req = 4'b1111;
    bus.tx_ready = 1'b1;
    run_tx(100, 5);
    checkCount++; if (ackLog.size() != 5) $display("[TB] FAIL fair_ack_count: got %0d expected 5", ackLog.size()); else passCount++;
    for (int i = 0; i < 5 && i < ackLog.size(); i++) begin
      checkCount++; if (ackLog[i] != expOrder[i]) $display("[TB] FAIL fair_order[%0d]: got %0d expected %0d", i, ackLog[i], expOrder[i]); else passCount++;
    end
    checkCount++; if (ackErr != 0) $display("[TB] FAIL fair_ack_shape: got %0d bad acks expected 0", ackErr); else passCount++;
  endtask

  task automatic test_port_en();
    int expOrder [4] = '{0, 1, 3, 0};
    applyReset();
    for (int i = 0; i < NP; i++) portData[i] = randData();
    driveData();
    bus.port_en = 4'b1011;
    bus.req = 4'b1111;
    bus.tx_ready = 1'b1;
    run_tx(100, 4);
    checkCount++; if (ackLog.size() != 4) $display("[TB] FAIL en_ack_count: got %0d expected 4", ackLog.size()); else passCount++;
    for (int i = 0; i < 4 && i < ackLog.size(); i++) begin
      checkCount++; if (ackLog[i] != expOrder[i]) $display("[TB] FAIL en_order[%0d]: got %0d expected %0d", i, ackLog[i], expOrder[i]); else passCount++;
    end
    checkCount++; if (ackErr != 0) $display("[TB] FAIL en_ack_shape: got %0d bad acks expected 0", ackErr); else passCount++;
  endtask

  task automatic test_ready_low();
    applyReset();
    portData[1] = randData();
    driveData();
    bus.port_en = 4'b1111;
    bus.req = 4'b0010;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkCount++; if (bus.rc_has_data !== 1'b1) $display("[TB] FAIL wait_rc c%0d: got %b expected 1", c, bus.rc_has_data); else passCount++;
      checkCount++; if (bus.data_to_tx !== portData[1]) $display("[TB] FAIL wait_data c%0d: got %h expected %h", c, bus.data_to_tx, portData[1]); else passCount++;
      checkCount++; if (bus.ack !== 4'b0000) $display("[TB] FAIL wait_ack c%0d: got %b expected 0000", c, bus.ack); else passCount++;
    end
    @(posedge clk);
    #1;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    checkCount++; if (bus.ack !== 4'b0010) $display("[TB] FAIL wait_accept_ack: got %b expected 0010", bus.ack); else passCount++;
    @(posedge clk);
    #1;
    bus.req = 4'b0000;
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_withdraw();
    applyReset();
    for (int i = 0; i < NP; i++) portData[i] = randData();
    driveData();
    bus.port_en = 4'b1111;
    bus.req = 4'b0010;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkCount++; if (bus.rc_has_data !== 1'b1) $display("[TB] FAIL wd_offer_rc: got %b expected 1", bus.rc_has_data); else passCount++;
    @(posedge clk);
    #1;
    bus.req = 4'b0000;
    @(negedge clk);
    checkCount++; if (bus.rc_has_data !== 1'b0) $display("[TB] FAIL wd_drop_rc: got %b expected 0", bus.rc_has_data); else passCount++;
    checkCount++; if (bus.ack !== 4'b0000) $display("[TB] FAIL wd_drop_ack: got %b expected 0000", bus.ack); else passCount++;
    @(posedge clk);
    #1;
    bus.req = 4'b1010;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    checkCount++; if (bus.busy !== 1'b0) $display("[TB] FAIL wd_idle_busy: got %b expected 0", bus.busy); else passCount++;
    @(negedge clk);
    checkCount++; if (bus.gnt_idx !== 2'd1) $display("[TB] FAIL wd_regrant_idx: got %0d expected 1", bus.gnt_idx); else passCount++;
    checkCount++; if (bus.ack !== 4'b0010) $display("[TB] FAIL wd_regrant_ack: got %b expected 0010", bus.ack); else passCount++;
  endtask

  task automatic test_reset_drain();
    applyReset();
    for (int i = 0; i < NP; i++) portData[i] = randData();
    driveData();
    bus.port_en = 4'b1111;
    bus.req = 4'b1000;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.req = 4'b0000;
    @(negedge clk);
    checkCount++; if (bus.busy !== 1'b1) $display("[TB] FAIL rd_drain_busy: got %b expected 1", bus.busy); else passCount++;
    checkCount++; if (bus.gnt_idx !== 2'd3) $display("[TB] FAIL rd_drain_idx: got %0d expected 3", bus.gnt_idx); else passCount++;
    #1 rst_n = 1'b0;
    #1;
    checkCount++; if (bus.busy !== 1'b0) $display("[TB] FAIL rd_async_busy: got %b expected 0", bus.busy); else passCount++;
    checkCount++; if (bus.gnt_idx !== 2'd0) $display("[TB] FAIL rd_async_idx: got %0d expected 0", bus.gnt_idx); else passCount++;
    checkCount++; if (bus.data_to_tx !== '0) $display("[TB] FAIL rd_async_data: got %h expected 0", bus.data_to_tx); else passCount++;
    checkCount++; if (bus.rc_has_data !== 1'b0 || bus.ack !== 4'b0000) $display("[TB] FAIL rd_async_offer: got rc=%b ack=%b expected 0/0000", bus.rc_has_data, bus.ack); else passCount++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    checkCount++; if (bus.gnt_idx !== 2'd2) $display("[TB] FAIL rd_fresh_idx: got %0d expected 2", bus.gnt_idx); else passCount++;
    checkCount++; if (bus.ack !== 4'b0100) $display("[TB] FAIL rd_fresh_ack: got %b expected 0100", bus.ack); else passCount++;
  endtask

  // Reference: one pending grant owner (or none), a drain flag, and a rotation pointer.
  task automatic test_random();
    int            owner = -1;
    bit            draining = 0;
    int            ptr = 0;
    int            lastIdx = 0;
    logic [DW-1:0] held = '0;
    int            highLeft = 0;
    int            lowLeft = 0;
    bit            live;
    bit            found;
    logic [NP-1:0] expAck;
    logic [DW-1:0] expData;
    applyReset();
    bus.port_en = 4'b1111;
    bus.tx_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      live = (owner >= 0) && bus.req[owner] && bus.port_en[owner];
      expAck = (live && bus.tx_ready) ? (4'b0001 << owner) : 4'b0000;
      expData = (owner >= 0) ? portData[owner] : (draining ? held : '0);
      checkCount++; if (bus.rc_has_data !== live) $display("[TB] FAIL rnd_rc c%0d: got %b expected %b", c, bus.rc_has_data, live); else passCount++;
      checkCount++; if (bus.ack !== expAck) $display("[TB] FAIL rnd_ack c%0d: got %b expected %b", c, bus.ack, expAck); else passCount++;
      checkCount++; if (bus.data_to_tx !== expData) $display("[TB] FAIL rnd_data c%0d: got %h expected %h", c, bus.data_to_tx, expData); else passCount++;
      checkCount++; if (bus.busy !== ((owner >= 0) || draining)) $display("[TB] FAIL rnd_busy c%0d: got %b expected %b", c, bus.busy, (owner >= 0) || draining); else passCount++;
      checkCount++; if (int'(bus.gnt_idx) != lastIdx) $display("[TB] FAIL rnd_gnt_idx c%0d: got %0d expected %0d", c, bus.gnt_idx, lastIdx); else passCount++;
      if (owner >= 0) begin
        if (!live) owner = -1;
        else if (bus.tx_ready) begin
          held = portData[owner];
          ptr = (owner + 1) % NP;
          owner = -1;
          draining = 1;
        end
      end else if (draining) begin
        if (!bus.tx_ready) draining = 0;
      end else begin
        found = 0;
        for (int k = 0; k < NP; k++) begin
          if (!found && bus.req[(ptr + k) % NP] && bus.port_en[(ptr + k) % NP]) begin
            owner = (ptr + k) % NP;
            lastIdx = owner;
            found = 1;
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NP; i++) begin
        if (expAck[i]) bus.req[i] = 1'b0;
        else if (bus.req[i]) begin
          if ($urandom_range(15) == 0) bus.req[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          bus.req[i] = 1'b1;
          portData[i] = randData();
        end
        if ($urandom_range(19) == 0) bus.port_en[i] = ~bus.port_en[i];
      end
      driveData();
      if (expAck != '0) begin
        highLeft = $urandom_range(1);
        lowLeft = $urandom_range(3, 1);
      end
      if (highLeft > 0) begin
        highLeft--;
        bus.tx_ready = 1'b1;
      end else if (lowLeft > 0) begin
        lowLeft--;
        bus.tx_ready = 1'b0;
      end else begin
        bus.tx_ready = ($urandom_range(7) != 0);
      end
    end
  endtask

  initial begin
    $display("[TB] starting tx_arbiter bench");
    test_reset();
    test_single();
    test_fair_all();
    test_port_en();
    test_ready_low();
    test_withdraw();
    test_reset_drain();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
